// File: rtl/reg_file.sv
// Two-read / one-write register file with per-entry valid bits and a sequential clear engine.
// Optional same-cycle write-to-read bypass is enabled with the REGFILE_BYPASS_EN macro.
module reg_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvld_a,
  output logic              rvld_b,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   idx_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0]    vld_r;
  logic                busy_s;
  logic                wr_acc_s;
  logic                last_s;
  logic [DATA_W:0]     rd_a_s;
  logic [DATA_W:0]     rd_b_s;

  // The clear engine finishes when the index points at the final entry.
  assign last_s = &idx_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a clr_req seen while clearing does not restart the walk.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; a clear request or reset in the same cycle drops the write.
  always_comb begin
    busy_s   = 1'b0;
    wr_acc_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (wen && !clr_req && !rst && !((ZERO_REG != 0) && (waddr == '0))) begin
          wr_acc_s = 1'b1;
        end else begin
          wr_acc_s = 1'b0;
        end
      end
      CLEAR: begin
        busy_s   = 1'b1;
        wr_acc_s = 1'b0;
      end
      default: begin
        busy_s   = 1'b0;
        wr_acc_s = 1'b0;
      end
    endcase
  end

  assign busy = busy_s;

  // Storage, valid bits and clear index.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= '0;
      vld_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (busy_s) begin
      mem_r[idx_r] <= '0;
      vld_r[idx_r] <= 1'b0;
      idx_r        <= idx_r + ADDR_W'(1);
    end else begin
      idx_r <= '0;
      if (wr_acc_s) begin
        mem_r[waddr] <= wdata;
        vld_r[waddr] <= 1'b1;
      end
    end
  end

  // Read port A: hardwired zero entry first, then optional bypass, then storage.
  always_comb begin
    rd_a_s = {vld_r[raddr_a], mem_r[raddr_a]};
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      rd_a_s = {1'b1, {DATA_W{1'b0}}};
`ifdef REGFILE_BYPASS_EN
    end else if (wr_acc_s && (raddr_a == waddr)) begin
      rd_a_s = {1'b1, wdata};
`endif
    end else begin
      rd_a_s = {vld_r[raddr_a], mem_r[raddr_a]};
    end
  end

  // Read port B mirrors port A with its own address.
  always_comb begin
    rd_b_s = {vld_r[raddr_b], mem_r[raddr_b]};
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      rd_b_s = {1'b1, {DATA_W{1'b0}}};
`ifdef REGFILE_BYPASS_EN
    end else if (wr_acc_s && (raddr_b == waddr)) begin
      rd_b_s = {1'b1, wdata};
`endif
    end else begin
      rd_b_s = {vld_r[raddr_b], mem_r[raddr_b]};
    end
  end

  assign rvld_a  = rd_a_s[DATA_W];
  assign rdata_a = rd_a_s[DATA_W-1:0];
  assign rvld_b  = rd_b_s[DATA_W];
  assign rdata_b = rd_b_s[DATA_W-1:0];

endmodule

// File: tb/tb_reg_file.sv
// Directed, scoreboard-driven bench for reg_file: a default instance and a ZERO_REG=1
// instance share stimulus; expectations are queued when driven and checked on sampling.
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst, wen, clr_req;
  logic [1:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [7:0] rdata_a, rdata_b, rdata_za, rdata_zb;
  logic       rvld_a, rvld_b, rvld_za, rvld_zb, busy, busy_z;

  int n_assert = 0;
  int n_fail   = 0;

  string      tag_q  [$];
  int         kind_q [$];
  logic [8:0] exp_q  [$];

  logic [7:0] old_v [4];

  always #5 clk = ~clk;

  reg_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .rvld_a(rvld_a), .rvld_b(rvld_b), .clr_req(clr_req), .busy(busy)
  );

  reg_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_za), .rdata_b(rdata_zb),
    .rvld_a(rvld_za), .rvld_b(rvld_zb), .clr_req(clr_req), .busy(busy_z)
  );

  // kind: 0 port A, 1 port B, 2 busy, 3 zero-reg port A, 4 zero-reg busy
  task automatic push(input string tag, input int kind, input logic [8:0] e);
    tag_q.push_back(tag);
    kind_q.push_back(kind);
    exp_q.push_back(e);
  endtask

  task automatic sample();
    string      tag;
    int         kind;
    logic [8:0] e;
    logic [8:0] obs;
    #1;
    while (kind_q.size() > 0) begin
      tag  = tag_q.pop_front();
      kind = kind_q.pop_front();
      e    = exp_q.pop_front();
      case (kind)
        0:       obs = {rvld_a, rdata_a};
        1:       obs = {rvld_b, rdata_b};
        2:       obs = {8'h00, busy};
        3:       obs = {rvld_za, rdata_za};
        4:       obs = {8'h00, busy_z};
        default: obs = 9'bx_xxxx_xxxx;
      endcase
      n_assert++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    old_v = '{8'hFF, 8'h21, 8'h32, 8'h43};
    rst = 1'b1; wen = 1'b0; clr_req = 1'b0;
    waddr = 2'd0; wdata = 8'h00; raddr_a = 2'd0; raddr_b = 2'd1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    push("rst_a0", 0, 9'h000);
    push("rst_b1", 1, 9'h000);
    push("rst_busy", 2, 9'h000);
    push("rst_z0", 3, {1'b1, 8'h00});
    sample();

    // Write A5 to entry 2, both ports on entry 2
    wen = 1'b1; waddr = 2'd2; wdata = 8'hA5; raddr_a = 2'd2; raddr_b = 2'd2;
`ifdef REGFILE_BYPASS_EN
    push("byp_a2", 0, {1'b1, 8'hA5});
`else
    push("byp_a2", 0, 9'h000);
`endif
    sample();
    tick();
    wen = 1'b0;
    push("wr_a2", 0, {1'b1, 8'hA5});
    push("wr_b2", 1, {1'b1, 8'hA5});
    sample();
    raddr_a = 2'd3;
    push("unwr_a3", 0, 9'h000);
    sample();

    // Same-cycle write of 5A over an older 11 in entry 3
    wen = 1'b1; waddr = 2'd3; wdata = 8'h11;
    tick();
    wdata = 8'h5A; raddr_a = 2'd3;
`ifdef REGFILE_BYPASS_EN
    push("byp_a3", 0, {1'b1, 8'h5A});
`else
    push("byp_a3", 0, {1'b1, 8'h11});
`endif
    sample();
    tick();
    wen = 1'b0;
    push("wr_a3", 0, {1'b1, 8'h5A});
    sample();

    // Fill all entries; entry 0 receives FF
    for (int k = 0; k < 4; k++) begin
      wen = 1'b1; waddr = 2'(k); wdata = old_v[k];
      tick();
    end
    wen = 1'b0; raddr_a = 2'd0; raddr_b = 2'd3;
    push("fill_a0", 0, {1'b1, 8'hFF});
    push("fill_b3", 1, {1'b1, 8'h43});
    push("zreg_a0", 3, {1'b1, 8'h00});
    sample();

    // Clear request together with a write to entry 1; write keeps being attempted while busy
    clr_req = 1'b1; wen = 1'b1; waddr = 2'd1; wdata = 8'h3C;
    tick();
    for (int c = 1; c <= 6; c++) begin
      clr_req = (c == 2);
      wen     = (c <= 4);
      push($sformatf("clr_busy_c%0d", c), 2, (c <= 4) ? 9'h001 : 9'h000);
      push($sformatf("clr_busyz_c%0d", c), 4, (c <= 4) ? 9'h001 : 9'h000);
      if (c <= 4) begin
        raddr_b = 2'(c - 1);
        push($sformatf("clr_old_b_c%0d", c), 1, {1'b1, old_v[c-1]});
      end
      if (c >= 2 && c <= 5) begin
        raddr_a = 2'(c - 2);
        push($sformatf("clr_zero_a_c%0d", c), 0, 9'h000);
      end
      sample();
      tick();
    end
    wen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      raddr_a = 2'(k);
      push($sformatf("post_clr_a%0d", k), 0, 9'h000);
      if (k == 0) push("post_clr_z0", 3, {1'b1, 8'h00});
      sample();
    end

    // Reset during the second clear cycle
    for (int k = 0; k < 4; k++) begin
      wen = 1'b1; waddr = 2'(k); wdata = old_v[k];
      tick();
    end
    wen = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    push("rstclr_busy_c1", 2, 9'h001);
    sample();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push("rstclr_busy", 2, 9'h000);
    sample();
    for (int k = 0; k < 4; k++) begin
      raddr_a = 2'(k); raddr_b = 2'(3 - k);
      push($sformatf("rstclr_a%0d", k), 0, 9'h000);
      push($sformatf("rstclr_b%0d", 3 - k), 1, 9'h000);
      sample();
    end
    tick();
    push("rstclr_no_resume", 2, 9'h000);
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
